// File: rtl/max3421_pkg.sv
// max3421_pkg: shared definitions for the MAX3421 SPI transaction sequencer.
//   - state_e    : sequencer states
//   - HIRQ_ADDR  : host interrupt-flag register polled when MAX3421_IRQ_POLL_EN is defined
//   - REG_MSB / DIR_BIT / ACKSTAT_BIT : command-byte layout
//   - READ_FILL  : byte shifted out during the data phase of a read
//   - cmd_byte() : builds the command byte, cnt_load() : timer load value for an N-cycle state
package max3421_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CMD,
        S_CMD_W,
        S_DAT,
        S_DAT_W,
        S_HOLD,
        S_GAP
    } state_e;

    localparam logic [4:0] HIRQ_ADDR   = 5'd25;
    localparam int         REG_MSB     = 7;
    localparam int         DIR_BIT     = 1;
    localparam int         ACKSTAT_BIT = 0;
    localparam logic [7:0] READ_FILL   = 8'h00;
    localparam int         CNT_W       = 8;

    // Command byte {reg[4:0], 0, dir, ackstat}; ACKSTAT is always cleared.
    function automatic logic [7:0] cmd_byte(input logic [4:0] addr, input logic wr);
        logic [7:0] b;
        b                 = '0;
        b[REG_MSB -: 5]   = addr;
        b[DIR_BIT]        = wr;
        b[ACKSTAT_BIT]    = 1'b0;
        return b;
    endfunction

    // A state that must last N cycles is loaded with N-1 and left when the
    // counter reads zero; N=0 degenerates to a single pass-through cycle.
    function automatic logic [CNT_W-1:0] cnt_load(input int n);
        if (n <= 0) begin
            return '0;
        end
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/max3421_seq_timer.sv
// max3421_seq_timer: loadable down-counter shared by the SETUP, HOLD and GAP states.
// Ports:
//   clk       in   block clock
//   rst_n     in   synchronous active-low reset
//   load      in   load load_val this cycle (takes priority over counting)
//   load_val  in   CNT_W-bit value to load
//   zero      out  counter currently reads zero (holds at zero)
module max3421_seq_timer
    import max3421_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/max3421_spi_seq.sv
// max3421_spi_seq: sequences complete MAX3421 register transactions (command
// byte + data byte under one slave-select) on top of a byte-level SPI master.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req, wr, reg_addr, wdata    CPU request (latched on acceptance)
//   busy, done                  busy from acceptance to IDLE; done = 1-cycle completion pulse
//   rdata, status               data-phase byte / command-phase byte received
//   ss_n                        MAX3421 slave select (active low)
//   spi_start, spi_din          SPI master start pulse and byte to send
//   spi_busy, spi_new_data, spi_dout  SPI master handshake and received byte
// Optional (macro MAX3421_IRQ_POLL_EN):
//   usb_int_n in, irq_flags out, irq_valid out -- automatic HIRQ read when the
//   interrupt line is low; CPU requests always win arbitration in IDLE.
module max3421_spi_seq
    import max3421_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2,
    parameter int GAP_CYC   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       wr,
    input  logic [4:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic [7:0] status,
    output logic       ss_n,
    output logic       spi_start,
    output logic [7:0] spi_din,
    input  logic       spi_busy,
    input  logic       spi_new_data,
    input  logic [7:0] spi_dout
`ifdef MAX3421_IRQ_POLL_EN
    ,
    input  logic       usb_int_n,
    output logic [7:0] irq_flags,
    output logic       irq_valid
`endif
);

    localparam logic [CNT_W-1:0] SETUP_LD = cnt_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD  = cnt_load(HOLD_CYC);
    localparam logic [CNT_W-1:0] GAP_LD   = cnt_load(GAP_CYC);

    state_e     state_q, state_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] status_q, status_d;
    logic       ss_n_q, ss_n_d;
    logic       spi_start_q, spi_start_d;
    logic [7:0] spi_din_q, spi_din_d;
    logic       wr_q, wr_d;
    logic [4:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
`ifdef MAX3421_IRQ_POLL_EN
    logic       poll_q, poll_d;
    logic [7:0] irq_flags_q, irq_flags_d;
    logic       irq_valid_q, irq_valid_d;
`endif

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             accept;

    max3421_seq_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        status_d    = status_q;
        ss_n_d      = ss_n_q;
        spi_start_d = 1'b0;
        spi_din_d   = spi_din_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        accept      = 1'b0;
`ifdef MAX3421_IRQ_POLL_EN
        poll_d      = poll_q;
        irq_flags_d = irq_flags_q;
        irq_valid_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // CPU request has priority, so a stuck interrupt line can
                // never starve the CPU.
                if (req) begin
                    accept  = 1'b1;
                    wr_d    = wr;
                    addr_d  = reg_addr;
                    wdata_d = wdata;
`ifdef MAX3421_IRQ_POLL_EN
                    poll_d  = 1'b0;
`endif
                end
`ifdef MAX3421_IRQ_POLL_EN
                else if (!usb_int_n) begin
                    accept  = 1'b1;
                    wr_d    = 1'b0;
                    addr_d  = HIRQ_ADDR;
                    wdata_d = READ_FILL;
                    poll_d  = 1'b1;
                end
`endif
                if (accept) begin
                    busy_d   = 1'b1;
                    ss_n_d   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tmr_zero) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (!spi_busy) begin
                    spi_start_d = 1'b1;
                    spi_din_d   = cmd_byte(addr_q, wr_q);
                    state_d     = S_CMD_W;
                end
            end
            S_CMD_W: begin
                if (spi_new_data) begin
                    status_d = spi_dout;
                    state_d  = S_DAT;
                end
            end
            S_DAT: begin
                if (!spi_busy) begin
                    spi_start_d = 1'b1;
                    spi_din_d   = wr_q ? wdata_q : READ_FILL;
                    state_d     = S_DAT_W;
                end
            end
            S_DAT_W: begin
                if (spi_new_data) begin
                    rdata_d  = spi_dout;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (tmr_zero) begin
                    ss_n_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (tmr_zero) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
`ifdef MAX3421_IRQ_POLL_EN
                    if (poll_q) begin
                        irq_flags_d = rdata_q;
                        irq_valid_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
`else
                    done_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= 8'h00;
            status_q    <= 8'h00;
            ss_n_q      <= 1'b1;
            spi_start_q <= 1'b0;
            spi_din_q   <= 8'h00;
            wr_q        <= 1'b0;
            addr_q      <= 5'd0;
            wdata_q     <= 8'h00;
`ifdef MAX3421_IRQ_POLL_EN
            poll_q      <= 1'b0;
            irq_flags_q <= 8'h00;
            irq_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            status_q    <= status_d;
            ss_n_q      <= ss_n_d;
            spi_start_q <= spi_start_d;
            spi_din_q   <= spi_din_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
`ifdef MAX3421_IRQ_POLL_EN
            poll_q      <= poll_d;
            irq_flags_q <= irq_flags_d;
            irq_valid_q <= irq_valid_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign status    = status_q;
    assign ss_n      = ss_n_q;
    assign spi_start = spi_start_q;
    assign spi_din   = spi_din_q;
`ifdef MAX3421_IRQ_POLL_EN
    assign irq_flags = irq_flags_q;
    assign irq_valid = irq_valid_q;
`endif

endmodule

// File: tb/tb_max3421_spi_seq.sv
// tb_max3421_spi_seq: table-driven bench for max3421_spi_seq with a small
// behavioural SPI master (fixed byte time, optional forced busy).
// Define MAX3421_IRQ_POLL_EN to also exercise the interrupt poll.
module tb_max3421_spi_seq;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       wr;
    logic [4:0] reg_addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic [7:0] status;
    logic       ss_n;
    logic       spi_start;
    logic [7:0] spi_din;
    logic       spi_busy;
    logic       spi_new_data;
    logic [7:0] spi_dout;
`ifdef MAX3421_IRQ_POLL_EN
    logic       usb_int_n;
    logic [7:0] irq_flags;
    logic       irq_valid;
`endif

    max3421_spi_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .wr           (wr),
        .reg_addr     (reg_addr),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .rdata        (rdata),
        .status       (status),
        .ss_n         (ss_n),
        .spi_start    (spi_start),
        .spi_din      (spi_din),
        .spi_busy     (spi_busy),
        .spi_new_data (spi_new_data),
        .spi_dout     (spi_dout)
`ifdef MAX3421_IRQ_POLL_EN
        ,
        .usb_int_n    (usb_int_n),
        .irq_flags    (irq_flags),
        .irq_valid    (irq_valid)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- SPI master model ----------------
    logic       model_busy;
    logic       hold_busy;
    int         bcnt;
    int         nd_cnt;
    int         resp_base;
    logic [7:0] resp [0:3];

    assign spi_busy = model_busy | hold_busy;

    initial begin
        model_busy   = 1'b0;
        spi_new_data = 1'b0;
        spi_dout     = 8'h00;
        bcnt         = 0;
        nd_cnt       = 0;
    end

    always @(negedge clk) begin
        int idx;
        spi_new_data = 1'b0;
        if (!rst_n) begin
            model_busy = 1'b0;
            bcnt       = 0;
        end else if (model_busy) begin
            if (bcnt == 0) begin
                model_busy   = 1'b0;
                spi_new_data = 1'b1;
                idx          = nd_cnt - resp_base;
                if (idx < 0) idx = 0;
                if (idx > 3) idx = 3;
                spi_dout     = resp[idx];
                nd_cnt       = nd_cnt + 1;
            end else begin
                bcnt = bcnt - 1;
            end
        end else if (spi_start) begin
            model_busy = 1'b1;
            bcnt       = 5;
        end
    end

    // ---------------- monitor ----------------
    int         start_cnt;
    int         done_cnt;
    int         irqv_cnt;
    int         viol_cnt;
    int         gap_viol;
    int         hi_run;
    logic       had_low;
    logic [7:0] din_log [0:255];

    initial begin
        start_cnt = 0;
        done_cnt  = 0;
        irqv_cnt  = 0;
        viol_cnt  = 0;
        gap_viol  = 0;
        hi_run    = 0;
        had_low   = 1'b0;
    end

    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            had_low = 1'b0;
            hi_run  = 0;
        end else begin
            if (spi_start) begin
                din_log[start_cnt % 256] = spi_din;
                start_cnt = start_cnt + 1;
                if (ss_n || spi_busy) viol_cnt = viol_cnt + 1;
            end
            if (done) done_cnt = done_cnt + 1;
`ifdef MAX3421_IRQ_POLL_EN
            if (irq_valid) irqv_cnt = irqv_cnt + 1;
`endif
            if (ss_n) begin
                hi_run = hi_run + 1;
            end else begin
                if (had_low && hi_run > 0 && hi_run < 4) gap_viol = gap_viol + 1;
                had_low = 1'b1;
                hi_run  = 0;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks;
    int n_fail;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Waits up to 400 cycles for done, sampling 1 time unit after each edge.
    task automatic wait_done(input string nm, output int lat);
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({nm, "_done_seen"}, 32'(lat > 0), 32'd1);
    endtask

    // Issues a one-cycle req, then scrambles the request inputs to prove they
    // were latched on acceptance.
    task automatic issue_req(input logic w, input logic [4:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        req = 1'b1; wr = w; reg_addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; wr = ~w; reg_addr = ~a; wdata = ~d;
    endtask

    typedef struct {
        string      nm;
        logic       w;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] e_cmd;
        logic [7:0] e_dat;
    } vec_t;

    vec_t vecs [0:4];

    initial begin
        int lat;
        int sbase;
        int dbase;
        int tmo;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req       = 1'b0;
        wr        = 1'b0;
        reg_addr  = 5'd0;
        wdata     = 8'h00;
        hold_busy = 1'b0;
        resp_base = 0;
        for (int i = 0; i < 4; i++) resp[i] = 8'h00;
`ifdef MAX3421_IRQ_POLL_EN
        usb_int_n = 1'b1;
`endif

        //            name     wr    addr   wdata  ret0   ret1   cmd    data
        vecs[0] = '{"wr17",   1'b1, 5'd17, 8'hA5, 8'h11, 8'h22, 8'h8A, 8'hA5};
        vecs[1] = '{"rd18",   1'b0, 5'd18, 8'hFF, 8'h40, 8'h3C, 8'h90, 8'h00};
        vecs[2] = '{"wr0",    1'b1, 5'd0,  8'h00, 8'h00, 8'hFF, 8'h02, 8'h00};
        vecs[3] = '{"rd31",   1'b0, 5'd31, 8'h5A, 8'h81, 8'h7E, 8'hF8, 8'h00};
        vecs[4] = '{"wr31",   1'b1, 5'd31, 8'hFF, 8'hC3, 8'h3C, 8'hFA, 8'hFF};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", 32'(ss_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ss_n",      32'(ss_n),      32'd1);
        check("idle_busy",      32'(busy),      32'd0);
        check("idle_done",      32'(done),      32'd0);
        check("idle_spi_start", 32'(spi_start), 32'd0);
        check("idle_spi_din",   32'(spi_din),   32'd0);
        check("idle_rdata",     32'(rdata),     32'd0);
        check("idle_status",    32'(status),    32'd0);

        // ---- table-driven transactions ----
        for (int v = 0; v < 5; v++) begin
            resp[0] = vecs[v].r0;
            resp[1] = vecs[v].r1;
            resp_base = nd_cnt;
            sbase = start_cnt;
            dbase = done_cnt;
            issue_req(vecs[v].w, vecs[v].a, vecs[v].d);
            wait_done(vecs[v].nm, lat);
            check({vecs[v].nm, "_latency"}, 32'(lat), 32'd24);
            check({vecs[v].nm, "_status"},  32'(status), 32'(vecs[v].r0));
            check({vecs[v].nm, "_rdata"},   32'(rdata),  32'(vecs[v].r1));
            check({vecs[v].nm, "_busy"},    32'(busy),   32'd0);
            check({vecs[v].nm, "_ss_n"},    32'(ss_n),   32'd1);
            @(posedge clk); #2;
            check({vecs[v].nm, "_cmd_byte"}, 32'(din_log[sbase % 256]),       32'(vecs[v].e_cmd));
            check({vecs[v].nm, "_dat_byte"}, 32'(din_log[(sbase + 1) % 256]), 32'(vecs[v].e_dat));
            check({vecs[v].nm, "_starts"},   32'(start_cnt - sbase), 32'd2);
            check({vecs[v].nm, "_dones"},    32'(done_cnt - dbase),  32'd1);
            $display("txn %s: cmd=%02h dat=%02h status=%02h rdata=%02h lat=%0d",
                     vecs[v].nm, din_log[sbase % 256], din_log[(sbase + 1) % 256], status, rdata, lat);
        end

        // ---- backpressure: SPI master busy for 20 cycles after ss_n falls ----
        resp[0] = 8'h5E; resp[1] = 8'hE5; resp_base = nd_cnt;
        sbase = start_cnt; dbase = done_cnt;
        hold_busy = 1'b1;
        issue_req(1'b1, 5'd7, 8'h3C);
        tmo = 1;
        for (int i = 0; i < 20; i++) begin
            if (!ss_n) begin tmo = 0; break; end
            @(posedge clk); #1;
        end
        check("bp_ss_fall", 32'(tmo), 32'd0);
        repeat (19) @(posedge clk);
        #1;
        check("bp_no_start_while_busy", 32'(start_cnt - sbase), 32'd0);
        hold_busy = 1'b0;
        @(posedge clk); #1;
        check("bp_start_after_release", 32'(spi_start), 32'd1);
        wait_done("bp", lat);
        @(posedge clk); #2;
        check("bp_starts",   32'(start_cnt - sbase), 32'd2);
        check("bp_cmd_byte", 32'(din_log[sbase % 256]), 32'h3A);
        check("bp_rdata",    32'(rdata), 32'hE5);
        $display("txn backpressure: starts=%0d rdata=%02h", start_cnt - sbase, rdata);

        // ---- req during DAT_W is ignored ----
        resp[0] = 8'h01; resp[1] = 8'h02; resp_base = nd_cnt;
        sbase = start_cnt; dbase = done_cnt;
        issue_req(1'b0, 5'd9, 8'h00);
        tmo = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (start_cnt - sbase >= 2) begin tmo = 0; break; end
        end
        check("busy_reach_dat_w", 32'(tmo), 32'd0);
        req = 1'b1; wr = 1'b1; reg_addr = 5'd3; wdata = 8'h77;
        @(posedge clk); #1;
        req = 1'b0;
        wait_done("busyreq", lat);
        repeat (10) @(posedge clk);
        #2;
        check("busyreq_idle",   32'(busy), 32'd0);
        check("busyreq_starts", 32'(start_cnt - sbase), 32'd2);
        check("busyreq_dones",  32'(done_cnt - dbase),  32'd1);
        $display("txn busy-ignore: starts=%0d dones=%0d", start_cnt - sbase, done_cnt - dbase);

        // ---- reset asserted in CMD_W ----
        resp[0] = 8'hAA; resp[1] = 8'hBB; resp_base = nd_cnt;
        sbase = start_cnt; dbase = done_cnt;
        issue_req(1'b1, 5'd4, 8'h44);
        tmo = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (start_cnt - sbase >= 1) begin tmo = 0; break; end
        end
        check("rst_reach_cmd_w", 32'(tmo), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_ss_n",      32'(ss_n),      32'd1);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_done",      32'(done),      32'd0);
        check("midrst_status",    32'(status),    32'd0);
        check("midrst_spi_start", 32'(spi_start), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        check("midrst_no_done", 32'(done_cnt - dbase), 32'd0);
        resp[0] = 8'h12; resp[1] = 8'h34; resp_base = nd_cnt;
        sbase = start_cnt;
        issue_req(1'b0, 5'd18, 8'h00);
        wait_done("postrst", lat);
        check("postrst_latency", 32'(lat),   32'd24);
        check("postrst_status",  32'(status), 32'h12);
        check("postrst_rdata",   32'(rdata),  32'h34);
        @(posedge clk); #2;
        check("postrst_cmd_byte", 32'(din_log[sbase % 256]), 32'h90);
        $display("txn after-reset: status=%02h rdata=%02h", status, rdata);

`ifdef MAX3421_IRQ_POLL_EN
        // ---- CPU req and interrupt in the same IDLE cycle ----
        resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h5C; resp[3] = 8'h77;
        resp_base = nd_cnt;
        sbase = start_cnt; dbase = done_cnt;
        @(posedge clk); #1;
        req = 1'b1; wr = 1'b1; reg_addr = 5'd3; wdata = 8'h33; usb_int_n = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        wait_done("poll_cpu", lat);
        check("poll_cpu_rdata", 32'(rdata), 32'h22);
        tmo = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (start_cnt - sbase >= 3) usb_int_n = 1'b1;
            if (irq_valid) begin tmo = 0; break; end
        end
        check("poll_irq_valid_seen", 32'(tmo),       32'd0);
        check("poll_irq_flags",      32'(irq_flags), 32'h77);
        check("poll_status",         32'(status),    32'h5C);
        check("poll_done_low",       32'(done),      32'd0);
        repeat (10) @(posedge clk);
        #2;
        check("poll_cpu_cmd",  32'(din_log[sbase % 256]),       32'h1A);
        check("poll_cpu_dat",  32'(din_log[(sbase + 1) % 256]), 32'h33);
        check("poll_hirq_cmd", 32'(din_log[(sbase + 2) % 256]), 32'hC8);
        check("poll_hirq_dat", 32'(din_log[(sbase + 3) % 256]), 32'h00);
        check("poll_irqv_cnt", 32'(irqv_cnt), 32'd1);
        check("poll_dones",    32'(done_cnt - dbase), 32'd1);
        check("poll_starts",   32'(start_cnt - sbase), 32'd4);
        $display("txn irq-poll: hirq_cmd=%02h irq_flags=%02h", din_log[(sbase + 2) % 256], irq_flags);
`endif

        check("start_protocol_violations", 32'(viol_cnt), 32'd0);
        check("ss_n_gap_violations",       32'(gap_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/max3421_spi_seq.md
Name: max3421_spi_seq

Overview:
- Sequences complete MAX3421 register transactions on top of the existing byte-level SPI master.
- Drives slave-select, the start/busy/new_data handshake and the command/data byte order, and captures the status and read bytes.
- Sits between the CPU IO decode and the SPI master, in the SPI master clock domain.
- Optionally arbitrates between CPU requests and an automatic interrupt-flag poll.

Parameters:
- SETUP_CYC, 2: clk cycles from ss_n falling to the first spi_start.
- HOLD_CYC, 2: clk cycles from the last spi_new_data to ss_n rising.
- GAP_CYC, 4: minimum clk cycles ss_n stays high between transactions.

Ports:
- clk  in  1  block clock, same clock as the SPI master.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  1  transaction request; sampled only in IDLE.
- wr  in  1  1 = register write, 0 = register read.
- reg_addr  in  5  MAX3421 register number.
- wdata  in  8  write data.
- busy  out  1  high from request acceptance until return to IDLE.
- done  out  1  one-cycle pulse when a CPU transaction completes.
- rdata  out  8  byte captured during the data phase.
- status  out  8  byte captured during the command phase.
- ss_n  out  1  MAX3421 slave select, active-low.
- spi_start  out  1  one-cycle start pulse to the SPI master.
- spi_din  out  8  byte to transmit.
- spi_busy  in  1  SPI master busy.
- spi_new_data  in  1  SPI master byte-complete pulse.
- spi_dout  in  8  byte received by the SPI master.

Behaviour:
- Reset values: ss_n=1, busy=0, done=0, spi_start=0, spi_din=0, rdata=0, status=0; state=IDLE. Reset asserted mid-transaction forces these values on the next edge, with no done pulse.
- Command byte: {reg_addr, 1'b0, wr, 1'b0}, so ACKSTAT=0.
- Data phase byte: wdata for a write, 8'h00 for a read.
- req, wr, reg_addr and wdata are latched on acceptance. Later changes to them have no effect on the transaction in progress.
- States:
  - IDLE: if req is high, latch the inputs, set busy=1 and ss_n=0 on the same edge, then go to SETUP.
  - SETUP: count SETUP_CYC cycles, then go to CMD.
  - CMD: wait for spi_busy=0, then issue spi_start for exactly one cycle with spi_din=command byte, then go to CMD_W.
  - CMD_W: on spi_new_data, status<=spi_dout, then go to DAT.
  - DAT: same handshake as CMD, with spi_din=data phase byte, then go to DAT_W.
  - DAT_W: on spi_new_data, rdata<=spi_dout (both reads and writes), then go to HOLD.
  - HOLD: count HOLD_CYC cycles, then ss_n<=1 and go to GAP.
  - GAP: count GAP_CYC cycles, then busy<=0, done<=1 for one cycle, and go to IDLE.
- Minimum latency from accepted req to done = SETUP_CYC + HOLD_CYC + GAP_CYC + 2 handshake cycles + the two SPI byte times.
- req while busy=1 is ignored: no queueing, no error.
- req held high across done is accepted as a new transaction on the first IDLE cycle.
- spi_start is never asserted while spi_busy=1 or while ss_n=1.
- spi_new_data arriving outside CMD_W or DAT_W is ignored.
- A zero count parameter means a 1-cycle pass through that state.

Optional Feature:
- Macro: MAX3421_IRQ_POLL_EN.
- When defined:
  - Adds ports usb_int_n (in, 1) and irq_flags (out, 8, reset 0) and irq_valid (out, 1, one-cycle pulse).
  - In IDLE with usb_int_n=0, the block runs a read of register 25 (HIRQ) through the same state path; busy is high during it.
  - At GAP end of that poll: irq_flags<=rdata and irq_valid pulses. done does not pulse, and rdata/status remain updated.
  - Arbitration in IDLE: a CPU req wins over the poll when both are present in the same cycle.
  - After a poll completes, the next IDLE cycle gives priority to a pending req before another poll, so no starvation.
- When undefined: the ports are absent, and usb_int_n behaviour is not present.

Decomposition:
- Shared package max3421_pkg:
  - state enum;
  - HIRQ_ADDR=5'd25;
  - command-byte bit positions (REG_MSB=7, DIR_BIT=1, ACKSTAT_BIT=0);
  - READ_FILL=8'h00.
- One sub-module: max3421_seq_timer, a loadable down-counter shared by SETUP, HOLD and GAP, with load/zero flags.

Test Plan:
- Write: req with wr=1, reg_addr=5'd17, wdata=8'hA5 → spi_din bytes 8'h8A then 8'hA5. ss_n is low throughout, done pulses once, and ss_n stays high ≥4 cycles afterwards.
- Read: wr=0, reg_addr=5'd18, SPI model returns 8'h40 then 8'h3C → spi_din bytes 8'h90 then 8'h00, status=8'h40, rdata=8'h3C at done.
- Backpressure: SPI model holds spi_busy=1 for 20 cycles after ss_n falls → spi_start first rises on the cycle after spi_busy falls, with exactly one pulse per byte.
- Busy: a second req pulse during DAT_W → ignored, exactly two spi_start pulses and one done.
- Reset: rst_n=0 in CMD_W → next edge ss_n=1, busy=0, no done; a subsequent req runs normally.
- MAX3421_IRQ_POLL_EN: usb_int_n=0 and req in the same IDLE cycle → CPU transaction first, then HIRQ read (spi_din 8'hC8), irq_flags equals returned byte, irq_valid pulses once.
